if_fetch_unit: RTL and testbench

Instruction-fetch stage. It owns the architectural PC register that feeds the next-PC adder, and it fetches one instruction per PC over a Wishbone classic master port. Each fetched instruction is handed to decode through a valid/ready handshake. When decode consumes the instruction, the unit loads the adder's result (PC+4 or PC+imm) as the new PC. A separate redirect path supports pipeline flushes.

---
 rtl/if_fetch_unit_pkg.sv | 7 +
 rtl/if_fetch_unit_if.sv | 15 +
 rtl/if_fetch_unit.sv | 85 ++++++++
 tb/tb_if_fetch_unit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared widths, NOP encoding and fetch state enum
package if_fetch_unit_pkg;
    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} fetch_state_t;
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: Wishbone classic bus between fetch master and memory slave
interface if_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                      wb_cyc;
    logic                      wb_stb;
    logic                      wb_we;
    logic [DATA_WIDTH/8-1:0]   wb_sel;
    logic [ADDR_WIDTH-1:0]     wb_adr;
    logic [DATA_WIDTH-1:0]     wb_dat;
    logic                      wb_ack;
    modport master (output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, input wb_dat, wb_ack);
    modport slave  (input wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, output wb_dat, wb_ack);
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC register plus one-at-a-time Wishbone instruction fetch with redirect
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_AW,
    parameter int DATA_WIDTH = WB_DW,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR = ADDR_WIDTH'(32'h8000_0000)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    input  logic [ADDR_WIDTH-1:0] next_pc_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] inst_pc_o,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    if_fetch_unit_if.master       wb
);
    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [ADDR_WIDTH-1:0] inst_pc_q;
    logic [DATA_WIDTH-1:0] inst_q;
    logic                  kill_q;

    function automatic logic [ADDR_WIDTH-1:0] align(input logic [ADDR_WIDTH-1:0] a);
        return a & ~ADDR_WIDTH'(3);
    endfunction

    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = state == S_HOLD;
    assign wb.wb_cyc    = state == S_WAIT;
    assign wb.wb_stb    = state == S_WAIT;
    assign wb.wb_we     = 1'b0;
    assign wb.wb_sel    = '1;
    assign wb.wb_adr    = adr_q;

    // fetch FSM; adr_q freezes the bus address so redirects during a transfer only touch pc_q
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_REQ;
            pc_q      <= PC_ADDR;
            adr_q     <= PC_ADDR;
            inst_pc_q <= PC_ADDR;
            inst_q    <= DATA_WIDTH'(NOP);
            kill_q    <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_i) pc_q <= align(redirect_pc_i);
                    else begin
                        state <= S_WAIT;
                        adr_q <= pc_q;
                    end
                end
                S_WAIT: begin
                    if (redirect_i) pc_q <= align(redirect_pc_i);
                    if (wb.wb_ack) begin
                        kill_q <= 1'b0;
                        if (kill_q || redirect_i) state <= S_REQ;
                        else begin
                            state     <= S_HOLD;
                            inst_q    <= wb.wb_dat;
                            inst_pc_q <= adr_q;
                        end
                    end else if (redirect_i) kill_q <= 1'b1;
                end
                S_HOLD: begin
                    if (redirect_i) begin
                        pc_q  <= align(redirect_pc_i);
                        state <= S_REQ;
                    end else if (inst_ready_i) begin
                        pc_q  <= align(next_pc_i);
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized fetch traffic checked against a transaction-level model
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] pc_o, next_pc_i = '0, redirect_pc_i = '0;
    logic        redirect_i = 1'b0, inst_ready_i = 1'b0;
    logic [31:0] inst_o, inst_pc_o;
    logic        inst_valid_o;

    if_fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    if_fetch_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .pc_o(pc_o), .next_pc_i(next_pc_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o),
        .inst_ready_i(inst_ready_i), .wb(bus)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // model of what the outside world must observe
    logic [31:0] exp_pc = 32'h8000_0000, exp_adr = 32'h8000_0000;
    logic [31:0] exp_inst = NOP, exp_ipc = 32'h8000_0000;
    logic        exp_cyc = 1'b0, exp_valid = 1'b0, discard = 1'b0;
    int          wait_left = 0;
    int          next_wait = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0050_0093 : (a ^ {a[15:0], a[31:16]} ^ 32'h1234_5678);
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        cmp("pc_o", pc_o, exp_pc);
        cmp("wb_cyc", 32'(bus.wb_cyc), 32'(exp_cyc));
        cmp("wb_stb", 32'(bus.wb_stb), 32'(exp_cyc));
        cmp("wb_we", 32'(bus.wb_we), 32'h0);
        cmp("wb_sel", 32'(bus.wb_sel), 32'hF);
        if (exp_cyc) cmp("wb_adr", bus.wb_adr, exp_adr);
        cmp("inst_valid", 32'(inst_valid_o), 32'(exp_valid));
        cmp("inst_o", inst_o, exp_inst);
        cmp("inst_pc", inst_pc_o, exp_ipc);
    endtask

    task automatic tick(input logic r, input logic rd, input logic [31:0] rp,
                        input logic rdy, input logic [31:0] np, input logic spur);
        logic ack;
        rst_i = r; redirect_i = rd; redirect_pc_i = rp; inst_ready_i = rdy; next_pc_i = np;
        ack = spur || (exp_cyc && wait_left == 0);
        bus.wb_ack = ack;
        bus.wb_dat = ack ? mem(bus.wb_adr) : $urandom;
        @(posedge clk_i);
        if (r) begin
            exp_pc = 32'h8000_0000; exp_cyc = 0; exp_valid = 0;
            exp_inst = NOP; exp_ipc = 32'h8000_0000; discard = 0;
        end else if (exp_valid) begin
            if (rd) begin exp_pc = rp & ~32'd3; exp_valid = 0; end
            else if (rdy) begin exp_pc = np & ~32'd3; exp_valid = 0; end
        end else if (exp_cyc) begin
            if (rd) begin exp_pc = rp & ~32'd3; discard = 1; end
            if (ack) begin
                exp_cyc = 0;
                if (!discard) begin exp_valid = 1; exp_inst = mem(exp_adr); exp_ipc = exp_adr; end
                discard = 0;
            end else if (wait_left > 0) wait_left--;
        end else if (rd) exp_pc = rp & ~32'd3;
        else begin
            exp_cyc = 1; exp_adr = exp_pc; discard = 0; wait_left = next_wait;
        end
        @(negedge clk_i);
        bus.wb_ack = 1'b0;
        compare_all();
    endtask

    initial begin
        bus.wb_ack = 1'b0;
        bus.wb_dat = '0;
        @(negedge clk_i);
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        cmp("rst_valid", 32'(inst_valid_o), 32'h0);
        cmp("rst_cyc", 32'(bus.wb_cyc), 32'h0);
        cmp("rst_inst", inst_o, 32'h0000_0013);
        cmp("rst_ipc", inst_pc_o, 32'h8000_0000);
        cmp("rst_pc", pc_o, 32'h8000_0000);
        next_wait = 0;
        tick(0, 0, 0, 0, 0, 0);
        cmp("first_adr", bus.wb_adr, 32'h8000_0000);
        cmp("first_cyc", 32'(bus.wb_cyc), 32'h1);
        tick(0, 0, 0, 0, 0, 0);
        cmp("first_valid", 32'(inst_valid_o), 32'h1);
        cmp("first_inst", inst_o, 32'h0050_0093);
        cmp("first_ipc", inst_pc_o, 32'h8000_0000);
        tick(0, 0, 0, 1, 32'h8000_0004, 0);
        cmp("hs_pc", pc_o, 32'h8000_0004);
        tick(0, 0, 0, 0, 0, 0);
        cmp("hs_adr", bus.wb_adr, 32'h8000_0004);
        tick(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 0, 32'h1111_1110, 0);
            cmp("hold_valid", 32'(inst_valid_o), 32'h1);
            cmp("hold_ipc", inst_pc_o, 32'h8000_0004);
            cmp("hold_cyc", 32'(bus.wb_cyc), 32'h0);
        end
        tick(0, 0, 0, 1, 32'h8000_0008, 0);
        cmp("hold_release", 32'(inst_valid_o), 32'h0);
        next_wait = 3;
        tick(0, 0, 0, 0, 0, 0);
        cmp("kill_adr", bus.wb_adr, 32'h8000_0008);
        tick(0, 1, 32'h8000_1000, 0, 0, 0);
        cmp("kill_adr_held", bus.wb_adr, 32'h8000_0008);
        cmp("kill_pc", pc_o, 32'h8000_1000);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 0);
        cmp("kill_valid", 32'(inst_valid_o), 32'h0);
        cmp("kill_cyc", 32'(bus.wb_cyc), 32'h0);
        next_wait = 2;
        tick(0, 0, 0, 0, 0, 0);
        cmp("redir_adr", bus.wb_adr, 32'h8000_1000);
        tick(1, 0, 0, 0, 0, 0);
        cmp("midrst_cyc", 32'(bus.wb_cyc), 32'h0);
        next_wait = 0;
        tick(0, 0, 0, 0, 0, 1);
        cmp("midrst_valid", 32'(inst_valid_o), 32'h0);
        cmp("midrst_adr", bus.wb_adr, 32'h8000_0000);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 32'hFFFF_FFFE, 0);
        cmp("wrap_pc", pc_o, 32'hFFFF_FFFC);
        tick(0, 0, 0, 0, 0, 0);
        cmp("wrap_adr", bus.wb_adr, 32'hFFFF_FFFC);
        tick(0, 0, 0, 0, 0, 0);
        cmp("wrap_ipc", inst_pc_o, 32'hFFFF_FFFC);
        tick(0, 0, 0, 1, 32'h0000_0000, 0);
        tick(0, 0, 0, 0, 0, 0);
        cmp("zero_adr", bus.wb_adr, 32'h0000_0000);
        for (int i = 0; i < 3000; i++) begin
            next_wait = $urandom_range(0, 3);
            tick($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, $urandom,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? $urandom : exp_pc + 32'd4, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
